// File: rtl/spartan_initiator_pkg.sv
// Shared Spartan bus definitions: type codes, header field positions, FSM states
// and the ID-width derivation used by every initiator.
package spartan_pkg;

    localparam logic [1:0] SP_RD_HDR    = 2'b00;
    localparam logic [1:0] SP_WR_HDR    = 2'b01;
    localparam logic [1:0] SP_DATA      = 2'b10;
    localparam logic [1:0] SP_DATA_LAST = 2'b11;

    localparam int SP_ADDR_LSB = 0;
    localparam int SP_ADDR_MSB = 31;
    localparam int SP_LEN_LSB  = 32;
    localparam int SP_LEN_MSB  = 35;
    localparam int SP_INC_BIT  = 39;
    localparam int SP_ID_LSB   = 41;

    typedef enum logic [2:0] {
        IDLE,
        RHDR,
        RRSP,
        RDAT,
        WHDR,
        WDAT,
        WRSP
    } sp_state_e;

    // ID occupies whatever is left between bit 41 and the mask field.
    function automatic int sp_idw(input int bwidth);
        return bwidth - (bwidth / 8) - 41;
    endfunction

endpackage

// File: rtl/spartan_initiator_if.sv
// Local command / write-data / read-return signals plus the Spartan master and
// response buses of one initiator. master = initiator view, slave = environment view.
interface spartan_initiator_if
    import spartan_pkg::*;
#(
    parameter int BWIDTH = 64,
    parameter int IDW    = sp_idw(BWIDTH)
) ();

    logic                  CMD_VLD;
    logic                  CMD_RDY;
    logic                  CMD_WR;
    logic [31:0]           CMD_ADDR;
    logic [3:0]            CMD_LEN;
    logic                  CMD_INC;
    logic [IDW-1:0]        CMD_ID;
    logic [BWIDTH/8-1:0]   CMD_MASK;

    logic                  WD_VLD;
    logic                  WD_RDY;
    logic [BWIDTH-1:0]     WD_DATA;

    logic                  RD_VLD;
    logic [BWIDTH-1:0]     RD_DATA;
    logic                  RD_LAST;

    logic                  DONE;
    logic [IDW-1:0]        DONE_ID;
    logic                  ERR;

    logic [BWIDTH+1:0]     SpMBUS;
    logic                  SpMVLD;
    logic                  SpMRDY;
    logic [BWIDTH+1:0]     SpSBUS;
    logic                  SpSVLD;
    logic                  SpSRDY;

    modport master (
        input  CMD_VLD, CMD_WR, CMD_ADDR, CMD_LEN, CMD_INC, CMD_ID, CMD_MASK,
        output CMD_RDY,
        input  WD_VLD, WD_DATA,
        output WD_RDY,
        output RD_VLD, RD_DATA, RD_LAST,
        output DONE, DONE_ID, ERR,
        output SpMBUS, SpMVLD,
        input  SpMRDY,
        input  SpSBUS, SpSVLD,
        output SpSRDY
    );

    modport slave (
        output CMD_VLD, CMD_WR, CMD_ADDR, CMD_LEN, CMD_INC, CMD_ID, CMD_MASK,
        input  CMD_RDY,
        output WD_VLD, WD_DATA,
        input  WD_RDY,
        input  RD_VLD, RD_DATA, RD_LAST,
        input  DONE, DONE_ID, ERR,
        input  SpMBUS, SpMVLD,
        output SpMRDY,
        output SpSBUS, SpSVLD,
        input  SpSRDY
    );

endinterface

// File: rtl/spartan_initiator_hdr_pack.sv
// Combinational Spartan request-header packer shared by the initiators.
module spartan_hdr_pack
    import spartan_pkg::*;
#(
    parameter int BWIDTH = 64,
    parameter int IDW    = sp_idw(BWIDTH)
) (
    input  logic                is_wr,
    input  logic [31:0]         addr,
    input  logic [3:0]          len,
    input  logic                inc,
    input  logic [IDW-1:0]      id,
    input  logic [BWIDTH/8-1:0] mask,
    output logic [BWIDTH+1:0]   hdr
);

    always_comb begin
        hdr = '0;
        hdr[BWIDTH+1:BWIDTH]         = is_wr ? SP_WR_HDR : SP_RD_HDR;
        hdr[SP_ADDR_MSB:SP_ADDR_LSB] = addr;
        hdr[SP_LEN_MSB:SP_LEN_LSB]   = len;
        hdr[SP_INC_BIT]              = inc;
        hdr[SP_ID_LSB +: IDW]        = id;
        hdr[BWIDTH-1 -: BWIDTH/8]    = is_wr ? mask : '0;
    end

endmodule

// File: rtl/spartan_initiator.sv
// Spartan bus initiator: one outstanding read or write burst at a time.
// Optional response watchdog enabled by defining SPARTAN_INITIATOR_TIMEOUT_EN.
module spartan_initiator
    import spartan_pkg::*;
#(
    parameter int BWIDTH = 64,
    parameter int IDW    = sp_idw(BWIDTH)
) (
    input  logic CLK,
    input  logic RST,
    spartan_initiator_if.master bus
);

    localparam int MW = BWIDTH / 8;

    if (BWIDTH != 64 && BWIDTH != 128 && BWIDTH != 256) begin : g_bad_width
        $error("spartan_initiator: BWIDTH must be 64, 128 or 256");
    end

    sp_state_e         state_q, state_d;

    logic              wr_q;
    logic [31:0]       addr_q;
    logic [3:0]        len_q;
    logic              inc_q;
    logic [IDW-1:0]    id_q;
    logic [MW-1:0]     mask_q;

    logic [3:0]        wcnt_q;
    logic [4:0]        rcnt_q;
    logic              done_q;
    logic [IDW-1:0]    done_id_q;
    logic              err_q;

    logic [BWIDTH+1:0] hdr;
    logic [1:0]        rsp_type;
    logic [IDW-1:0]    rsp_id;
    logic              cmd_fire;
    logic              rsp_fire;
    logic              timeout;

    logic              set_err;
    logic              set_done;
    logic              latch_id;
    logic [IDW-1:0]    id_d;
    logic              rcnt_inc;
    logic              wcnt_load;
    logic              wcnt_dec;

    assign rsp_type = bus.SpSBUS[BWIDTH+1:BWIDTH];
    assign rsp_id   = bus.SpSBUS[SP_ID_LSB +: IDW];
    assign cmd_fire = bus.CMD_VLD && (state_q == IDLE);
    assign rsp_fire = bus.SpSVLD && bus.SpSRDY;

    assign bus.DONE    = done_q;
    assign bus.DONE_ID = done_id_q;
    assign bus.ERR     = err_q;

    spartan_hdr_pack #(
        .BWIDTH (BWIDTH),
        .IDW    (IDW)
    ) u_hdr (
        .is_wr (wr_q),
        .addr  (addr_q),
        .len   (len_q),
        .inc   (inc_q),
        .id    (id_q),
        .mask  (mask_q),
        .hdr   (hdr)
    );

`ifdef SPARTAN_INITIATOR_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        waiting;

    assign waiting = (state_q == RRSP) || (state_q == RDAT) || (state_q == WRSP);
    assign timeout = waiting && (to_cnt_q == 16'hFFFF);

    always_ff @(posedge CLK) begin
        if (RST || !waiting || rsp_fire) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.CMD_RDY = 1'b0;
        bus.WD_RDY  = 1'b0;
        bus.RD_VLD  = 1'b0;
        bus.RD_DATA = '0;
        bus.RD_LAST = 1'b0;
        bus.SpMVLD  = 1'b0;
        bus.SpMBUS  = '0;
        bus.SpSRDY  = 1'b0;
        set_err     = 1'b0;
        set_done    = 1'b0;
        latch_id    = 1'b0;
        id_d        = rsp_id;
        rcnt_inc    = 1'b0;
        wcnt_load   = 1'b0;
        wcnt_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                bus.CMD_RDY = 1'b1;
                if (bus.CMD_VLD) begin
                    state_d = bus.CMD_WR ? WHDR : RHDR;
                end
            end
            RHDR: begin
                bus.SpMVLD = 1'b1;
                bus.SpMBUS = hdr;
                if (bus.SpMRDY) begin
                    state_d = RRSP;
                end
            end
            RRSP: begin
                bus.SpSRDY = 1'b1;
                if (bus.SpSVLD) begin
                    if (rsp_type == SP_WR_HDR) begin
                        latch_id = 1'b1;
                        state_d  = RDAT;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            RDAT: begin
                bus.SpSRDY = 1'b1;
                if (bus.SpSVLD) begin
                    if (rsp_type[1]) begin
                        bus.RD_VLD  = 1'b1;
                        bus.RD_DATA = bus.SpSBUS[BWIDTH-1:0];
                        rcnt_inc    = 1'b1;
                        // rcnt_q is the number of beats already delivered
                        if (rsp_type == SP_DATA_LAST) begin
                            bus.RD_LAST = 1'b1;
                            set_done    = 1'b1;
                            state_d     = IDLE;
                            set_err     = (rcnt_q < {1'b0, len_q});
                        end else begin
                            set_err     = (rcnt_q > {1'b0, len_q});
                        end
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            WHDR: begin
                bus.SpMVLD = 1'b1;
                bus.SpMBUS = hdr;
                if (bus.SpMRDY) begin
                    wcnt_load = 1'b1;
                    state_d   = WDAT;
                end
            end
            WDAT: begin
                bus.SpMVLD = bus.WD_VLD;
                bus.WD_RDY = bus.SpMRDY;
                if (bus.WD_VLD) begin
                    bus.SpMBUS = {(wcnt_q == 4'd0) ? SP_DATA_LAST : SP_DATA, bus.WD_DATA};
                    if (bus.SpMRDY) begin
                        wcnt_dec = 1'b1;
                        if (wcnt_q == 4'd0) begin
                            state_d = WRSP;
                        end
                    end
                end
            end
            WRSP: begin
                bus.SpSRDY = 1'b1;
                if (bus.SpSVLD && (rsp_type == SP_RD_HDR)) begin
                    latch_id = 1'b1;
                    set_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog expiry abandons the transaction and reports the issued ID.
        if (timeout) begin
            set_err  = 1'b1;
            set_done = 1'b1;
            latch_id = 1'b1;
            id_d     = id_q;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            inc_q     <= 1'b0;
            id_q      <= '0;
            mask_q    <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (cmd_fire) begin
                wr_q   <= bus.CMD_WR;
                addr_q <= bus.CMD_ADDR;
                len_q  <= bus.CMD_LEN;
                inc_q  <= bus.CMD_INC;
                id_q   <= bus.CMD_ID;
                mask_q <= bus.CMD_MASK;
            end

            if (wcnt_load) begin
                wcnt_q <= len_q;
            end else if (wcnt_dec) begin
                wcnt_q <= wcnt_q - 4'd1;
            end

            if (cmd_fire) begin
                rcnt_q <= '0;
            end else if (rcnt_inc && (rcnt_q != '1)) begin
                rcnt_q <= rcnt_q + 5'd1;
            end

            done_q <= set_done;
            if (latch_id) begin
                done_id_q <= id_d;
            end
            if (set_err || (latch_id && (id_d != id_q))) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spartan_initiator.sv
// Directed self-checking bench for spartan_initiator (BWIDTH=64, IDW=15).
module tb_spartan_initiator;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    spartan_initiator_if #(.BWIDTH(64)) bus ();

    spartan_initiator #(.BWIDTH(64)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic inc, input logic [14:0] id, input logic [7:0] mask);
        bus.CMD_VLD  = 1'b1;
        bus.CMD_WR   = wr;
        bus.CMD_ADDR = addr;
        bus.CMD_LEN  = len;
        bus.CMD_INC  = inc;
        bus.CMD_ID   = id;
        bus.CMD_MASK = mask;
        tick();
        bus.CMD_VLD  = 1'b0;
        #1;
    endtask

    initial begin
        logic [63:0] beat;
        logic [15:0] vpat;
        logic [15:0] rpat;
        int          got;
        rst          = 1'b1;
        bus.CMD_VLD  = 1'b0;
        bus.CMD_WR   = 1'b0;
        bus.CMD_ADDR = '0;
        bus.CMD_LEN  = '0;
        bus.CMD_INC  = 1'b0;
        bus.CMD_ID   = '0;
        bus.CMD_MASK = '0;
        bus.WD_VLD   = 1'b0;
        bus.WD_DATA  = '0;
        bus.SpMRDY   = 1'b0;
        bus.SpSBUS   = '0;
        bus.SpSVLD   = 1'b0;
        tick();
        tick();

        chk("rst_cmd_rdy", bus.CMD_RDY, 1'b1);
        chk("rst_spmvld",  bus.SpMVLD,  1'b0);
        chk("rst_spmbus",  bus.SpMBUS,  66'h0);
        chk("rst_err",     bus.ERR,     1'b0);
        chk("rst_done",    bus.DONE,    1'b0);
        chk("rst_rd_vld",  bus.RD_VLD,  1'b0);
        chk("rst_spsrdy",  bus.SpSRDY,  1'b0);
        rst = 1'b0;
        bus.SpMRDY = 1'b1;
        tick();

        // Read, ADDR 0x1000, LEN 3, INC, ID 5
        issue(1'b0, 32'h1000, 4'd3, 1'b1, 15'h5, 8'hFF);
        chk("rd_hdr_vld", bus.SpMVLD,  1'b1);
        chk("rd_hdr",     bus.SpMBUS,  66'h0_0000_0A83_0000_1000);
        chk("rd_cmd_rdy", bus.CMD_RDY, 1'b0);
        tick();
        chk("rrsp_mvld",  bus.SpMVLD,  1'b0);
        chk("rrsp_mbus",  bus.SpMBUS,  66'h0);
        chk("rrsp_srdy",  bus.SpSRDY,  1'b1);
        bus.SpSVLD = 1'b1;
        bus.SpSBUS = 66'h1_0000_0A00_0000_0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            beat = 64'hA0A0_0000_0000_0000 + 64'(i);
            bus.SpSBUS = {(i == 3) ? 2'b11 : 2'b10, beat};
            #1;
            chk("rd_vld",  bus.RD_VLD,  1'b1);
            chk("rd_data", bus.RD_DATA, beat);
            chk("rd_last", bus.RD_LAST, (i == 3) ? 1'b1 : 1'b0);
            tick();
        end
        bus.SpSVLD = 1'b0;
        bus.SpSBUS = '0;
        #1;
        chk("rd_done",    bus.DONE,    1'b1);
        chk("rd_done_id", bus.DONE_ID, 15'h5);
        chk("rd_err",     bus.ERR,     1'b0);
        chk("rd_idle",    bus.CMD_RDY, 1'b1);
        tick();
        chk("rd_done_pulse", bus.DONE, 1'b0);

        // Write, LEN 1, MASK 0x0F, ID 7
        issue(1'b1, 32'h2000, 4'd1, 1'b1, 15'h7, 8'h0F);
        chk("wr_hdr", bus.SpMBUS, 66'h1_0F00_0E81_0000_2000);
        tick();
        bus.WD_VLD  = 1'b1;
        bus.WD_DATA = 64'h1111_2222_3333_4444;
        #1;
        chk("wr_d0",     bus.SpMBUS, {2'b10, 64'h1111_2222_3333_4444});
        chk("wr_d0_rdy", bus.WD_RDY, 1'b1);
        tick();
        bus.WD_DATA = 64'h5555_6666_7777_8888;
        #1;
        chk("wr_d1", bus.SpMBUS, {2'b11, 64'h5555_6666_7777_8888});
        tick();
        bus.WD_VLD = 1'b0;
        #1;
        chk("wrsp_mvld", bus.SpMVLD, 1'b0);
        chk("wrsp_srdy", bus.SpSRDY, 1'b1);
        chk("wrsp_no_done", bus.DONE, 1'b0);
        bus.SpSVLD = 1'b1;
        bus.SpSBUS = 66'h0_0000_0E00_0000_0000;
        tick();
        bus.SpSVLD = 1'b0;
        #1;
        chk("wr_done",    bus.DONE,    1'b1);
        chk("wr_done_id", bus.DONE_ID, 15'h7);
        chk("wr_err",     bus.ERR,     1'b0);
        tick();

        // Write LEN 3 with target stalls and source gaps
        issue(1'b1, 32'h3000, 4'd3, 1'b0, 15'h3, 8'hFF);
        tick();
        vpat = 16'b0000_0001_1010_1111;
        rpat = 16'b0000_0001_1111_0001;
        got  = 0;
        for (int c = 0; c < 16 && got < 4; c++) begin
            bus.WD_VLD  = vpat[c];
            bus.SpMRDY  = rpat[c];
            bus.WD_DATA = 64'hC0DE_0000_0000_0000 + 64'(got);
            #1;
            chk("st_mvld", bus.SpMVLD, vpat[c]);
            chk("st_wrdy", bus.WD_RDY, rpat[c]);
            if (vpat[c]) begin
                chk("st_beat", bus.SpMBUS,
                    {(got == 3) ? 2'b11 : 2'b10, 64'hC0DE_0000_0000_0000 + 64'(got)});
            end
            if (bus.SpMVLD && bus.SpMRDY) begin
                got++;
            end
            tick();
        end
        bus.WD_VLD = 1'b0;
        bus.SpMRDY = 1'b1;
        #1;
        chk("st_count", 32'(got), 32'd4);
        chk("st_wrsp",  bus.SpSRDY, 1'b1);
        bus.SpSVLD = 1'b1;
        bus.SpSBUS = 66'h0_0000_0600_0000_0000;
        tick();
        bus.SpSVLD = 1'b0;
        #1;
        chk("st_done",    bus.DONE,    1'b1);
        chk("st_done_id", bus.DONE_ID, 15'h3);
        chk("st_err",     bus.ERR,     1'b0);
        tick();

        // Read returning ID 6 for issued ID 5
        issue(1'b0, 32'h0040, 4'd0, 1'b1, 15'h5, 8'h00);
        tick();
        bus.SpSVLD = 1'b1;
        bus.SpSBUS = 66'h1_0000_0C00_0000_0000;
        tick();
        chk("idm_err", bus.ERR, 1'b1);
        bus.SpSBUS = {2'b11, 64'h0000_0000_0000_DEAD};
        #1;
        chk("idm_last", bus.RD_LAST, 1'b1);
        tick();
        bus.SpSVLD = 1'b0;
        #1;
        chk("idm_done",    bus.DONE,    1'b1);
        chk("idm_done_id", bus.DONE_ID, 15'h6);
        tick();

        // Reset in the middle of an 8-beat write
        issue(1'b1, 32'h5000, 4'd7, 1'b1, 15'h2, 8'hAA);
        tick();
        bus.WD_VLD  = 1'b1;
        bus.WD_DATA = 64'h0123_4567_89AB_CDEF;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_cmd_rdy", bus.CMD_RDY, 1'b1);
        chk("rst_mid_mvld",    bus.SpMVLD,  1'b0);
        chk("rst_mid_mbus",    bus.SpMBUS,  66'h0);
        chk("rst_mid_err",     bus.ERR,     1'b0);
        chk("rst_mid_wrdy",    bus.WD_RDY,  1'b0);
        bus.WD_VLD = 1'b0;
        tick();

        // Read of 4 beats terminated early on beat 2
        issue(1'b0, 32'h0100, 4'd3, 1'b1, 15'h4, 8'h00);
        tick();
        bus.SpSVLD = 1'b1;
        bus.SpSBUS = 66'h1_0000_0800_0000_0000;
        tick();
        chk("early_hdr_err", bus.ERR, 1'b0);
        bus.SpSBUS = {2'b10, 64'h1};
        tick();
        chk("early_b1_err", bus.ERR, 1'b0);
        bus.SpSBUS = {2'b11, 64'h2};
        #1;
        chk("early_last", bus.RD_LAST, 1'b1);
        tick();
        bus.SpSVLD = 1'b0;
        #1;
        chk("early_err",     bus.ERR,     1'b1);
        chk("early_done",    bus.DONE,    1'b1);
        chk("early_done_id", bus.DONE_ID, 15'h4);
        chk("early_idle",    bus.CMD_RDY, 1'b1);
        tick();

`ifdef SPARTAN_INITIATOR_TIMEOUT_EN
        begin
            logic seen;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            issue(1'b0, 32'h0200, 4'd0, 1'b1, 15'h9, 8'h00);
            tick();
            seen = 1'b0;
            for (int n = 0; n < 70000 && !seen; n++) begin
                tick();
                seen = bus.DONE;
            end
            chk("to_done",    seen,        1'b1);
            chk("to_err",     bus.ERR,     1'b1);
            chk("to_done_id", bus.DONE_ID, 15'h9);
            chk("to_idle",    bus.CMD_RDY, 1'b1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
